// File: rtl/zap_wb_arbiter_n.sv
// Round-robin Wishbone B3 arbiter merging NUM_CH masters onto one bus.
// Bursts are never broken; a watchdog aborts hung slave accesses with an error.
module zap_wb_arbiter_n #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,

    input  logic [NUM_CH-1:0]     i_m_wb_cyc,
    input  logic [NUM_CH-1:0]     i_m_wb_stb,
    input  logic [NUM_CH-1:0]     i_m_wb_wen,
    input  logic [4*NUM_CH-1:0]   i_m_wb_sel,
    input  logic [32*NUM_CH-1:0]  i_m_wb_dat,
    input  logic [32*NUM_CH-1:0]  i_m_wb_adr,
    input  logic [3*NUM_CH-1:0]   i_m_wb_cti,
    output logic [NUM_CH-1:0]     o_m_wb_ack,
    output logic [NUM_CH-1:0]     o_m_wb_err,

    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_wen,
    output logic [3:0]            o_wb_sel,
    output logic [31:0]           o_wb_dat,
    output logic [31:0]           o_wb_adr,
    output logic [2:0]            o_wb_cti,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_err,

    output logic [NUM_CH-1:0]     o_grant
);

    localparam int         IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int         TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [2:0] CTI_EOB = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_ABORT
    } state_t;

    state_t              state_ff, state_nx;
    logic [NUM_CH-1:0]   grant_ff, grant_nx;
    logic [IW-1:0]       last_ff,  last_nx;
    logic [TW-1:0]       tcnt_ff,  tcnt_nx;

    logic [3:0]          m_sel [NUM_CH];
    logic [31:0]         m_dat [NUM_CH];
    logic [31:0]         m_adr [NUM_CH];
    logic [2:0]          m_cti [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign m_sel[k] = i_m_wb_sel[4*k +: 4];
        assign m_dat[k] = i_m_wb_dat[32*k +: 32];
        assign m_adr[k] = i_m_wb_adr[32*k +: 32];
        assign m_cti[k] = i_m_wb_cti[3*k +: 3];
    end

    // First requester after 'last', wrapping; 'last' itself is checked last.
    function automatic logic [IW-1:0] pick(input logic [NUM_CH-1:0] req,
                                           input logic [IW-1:0]     last);
        logic [IW-1:0] idx;
        pick = last;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = IW'((int'(last) + i) % NUM_CH);
            if (req[idx]) pick = idx;
        end
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [IW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // While owning, last_ff holds the owner index, so it doubles as the mux select.
    logic        g_cyc, g_stb;
    logic [2:0]  g_cti;
    logic        any_resp, timeout, release_bus;
    logic [NUM_CH-1:0] others;
    logic [IW-1:0]     win_all, win_oth;

    assign g_cyc    = i_m_wb_cyc[last_ff];
    assign g_stb    = i_m_wb_stb[last_ff];
    assign g_cti    = m_cti[last_ff];
    assign any_resp = i_wb_ack | i_wb_err;
    assign others   = i_m_wb_stb & ~grant_ff;
    assign win_all  = pick(i_m_wb_stb, last_ff);
    assign win_oth  = pick(others, last_ff);

    assign timeout = (TIMEOUT > 0) && (state_ff == S_OWN) && g_stb && !any_resp &&
                     (tcnt_ff == TW'(TIMEOUT - 1));

    assign release_bus = (state_ff == S_OWN) &&
                         ((any_resp && g_cti == CTI_EOB) || (!g_stb && !g_cyc));

    assign o_grant = grant_ff;

    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_nx   = state_ff;
        grant_nx   = grant_ff;
        last_nx    = last_ff;
        tcnt_nx    = tcnt_ff;
        o_m_wb_ack = '0;
        o_m_wb_err = '0;
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_wen   = 1'b0;
        o_wb_sel   = '0;
        o_wb_dat   = '0;
        o_wb_adr   = '0;
        o_wb_cti   = CTI_EOB;

        case (state_ff)
            S_IDLE: begin
                if (|i_m_wb_stb) begin
                    state_nx = S_OWN;
                    grant_nx = onehot(win_all);
                    last_nx  = win_all;
                    tcnt_nx  = '0;
                end
            end

            S_OWN: begin
                o_wb_cyc   = g_cyc;
                o_wb_stb   = g_stb;
                o_wb_wen   = i_m_wb_wen[last_ff];
                o_wb_sel   = m_sel[last_ff];
                o_wb_dat   = m_dat[last_ff];
                o_wb_adr   = m_adr[last_ff];
                o_wb_cti   = g_cti;
                o_m_wb_ack = grant_ff & {NUM_CH{any_resp | timeout}};
                o_m_wb_err = grant_ff & {NUM_CH{i_wb_err | timeout}};

                if (timeout) begin
                    state_nx = S_ABORT;
                    grant_nx = '0;
                    tcnt_nx  = '0;
                end else if (release_bus) begin
                    tcnt_nx = '0;
                    if (|others) begin
                        grant_nx = onehot(win_oth);
                        last_nx  = win_oth;
                    end else if (!g_stb) begin
                        state_nx = S_IDLE;
                        grant_nx = '0;
                    end
                end else if (any_resp) begin
                    tcnt_nx = '0;
                end else if (g_stb && TIMEOUT > 0) begin
                    tcnt_nx = tcnt_ff + TW'(1);
                end
            end

            S_ABORT: begin
                state_nx = S_IDLE;
                tcnt_nx  = '0;
            end

            default: begin
                state_nx = S_IDLE;
                grant_nx = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of evaluation order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_ff <= S_IDLE;
            grant_ff <= '0;
            last_ff  <= IW'(NUM_CH - 1);
            tcnt_ff  <= '0;
        end else begin
            state_ff <= state_nx;
            grant_ff <= grant_nx;
            last_ff  <= last_nx;
            tcnt_ff  <= tcnt_nx;
        end
    end

endmodule

// File: doc/zap_wb_arbiter_n.md
Name: zap_wb_arbiter_n

Overview:
- N-master Wishbone B3 arbiter. Merges NUM_CH requesting masters (I-cache, D-cache, MMU walker, DMA) onto one common bus.
- Round-robin arbitration that never breaks a burst.
- Per-transaction watchdog: aborts a hung slave access with an error to the owning master.
- Generalised successor of the two-channel code/data merger. Sits between the cache/walker ports and the SoC interconnect.

Parameters:
- NUM_CH, 4: number of masters, 2..8.
- TIMEOUT, 256: cycles without ack/err before abort. 0 disables the watchdog.

Ports:
- i_clk  in  1  clock, all logic on posedge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_m_wb_cyc  in  NUM_CH  per-master CYC.
- i_m_wb_stb  in  NUM_CH  per-master STB.
- i_m_wb_wen  in  NUM_CH  per-master write enable.
- i_m_wb_sel  in  4*NUM_CH  byte selects; master k at [4k+3:4k].
- i_m_wb_dat  in  32*NUM_CH  write data; master k at [32k+31:32k].
- i_m_wb_adr  in  32*NUM_CH  address, same packing as i_m_wb_dat.
- i_m_wb_cti  in  3*NUM_CH  cycle type; 3'b111 = end of burst (EOB).
- o_m_wb_ack  out  NUM_CH  ack to master (ack OR err).
- o_m_wb_err  out  NUM_CH  error to master.
- o_wb_cyc, o_wb_stb, o_wb_wen  out  1 each  common bus.
- o_wb_sel  out  4  common bus.
- o_wb_dat, o_wb_adr  out  32 each  common bus.
- o_wb_cti  out  3  common bus.
- i_wb_ack, i_wb_err  in  1 each  slave response.
- o_grant  out  NUM_CH  one-hot current owner; 0 when idle or aborting.

Behaviour:
- Reset (asynchronous, i_reset_n=0):
  - state=IDLE, grant_ff=0, last_ff=NUM_CH-1, tcnt=0.
  - Bus outputs driven from state, so they take their idle values immediately: o_wb_cyc=o_wb_stb=o_wb_wen=0, sel/dat/adr=0, o_wb_cti=3'b111.
  - All o_m_wb_ack/err=0.
- States: IDLE, OWN, ABORT.
- Winner selection:
  - Scan i_m_wb_stb starting at index last_ff+1, wrapping modulo NUM_CH.
  - The first set bit wins. The previous owner therefore has lowest priority.
  - From reset, channel 0 wins ties.
- IDLE:
  - Any stb set → grant_ff=onehot(winner), last_ff=winner, state=OWN.
  - Latency: stb seen in cycle n → bus shows that master in cycle n+1.
- OWN:
  - o_wb_* is a combinational mux of the granted master's inputs.
  - i_wb_ack/i_wb_err route only to the granted index.
  - Release occurs when either:
    - (i_wb_ack|i_wb_err) and granted cti==3'b111; or
    - granted stb==0 and cyc==0.
  - On release, if any stb (excluding the released channel's own stb) → back-to-back grant to the new winner, stay OWN; otherwise → IDLE.
  - If the released master is the only requester, it is re-granted.
  - A burst (cti 3'b001/3'b010) is never interrupted by other requests.
- Watchdog (TIMEOUT>0):
  - tcnt clears on grant change and on any ack/err; otherwise it increments while granted stb=1.
  - When tcnt==TIMEOUT-1 with no ack/err this cycle: pulse o_m_wb_err[g] and o_m_wb_ack[g] for one cycle, then state=ABORT, grant_ff=0.
  - Counter width is $clog2(TIMEOUT+1).
- ABORT:
  - Exactly one cycle: o_wb_cyc=o_wb_stb=0, cti=3'b111.
  - A late slave ack/err is dropped (routed nowhere).
  - Next state IDLE, re-arbitrating from last_ff.
- Simultaneous events:
  - ack and timeout in the same cycle → ack wins, no err.
  - err on a non-EOB beat → err passed to the master; the burst continues until EOB or stb drop.
- Bus ack/err arriving in IDLE is ignored.
- Reset mid-burst: outputs idle immediately; no ack is generated.

Test Plan:
1. Reset then stb on ch0 and ch2 together → ch0 granted at cycle +1, o_grant=4'b0001; on EOB ack, ch2 granted next cycle with no idle gap.
2. All four masters hold stb with single-beat EOB transfers → grant order 0,1,2,3,0, each acked once per rotation, no starvation.
3. ch1 runs a 4-beat incrementing burst (cti 010,010,010,111) while ch0 requests → ch0 not granted until the cycle after the 4th ack.
4. TIMEOUT=8, ch3 granted, slave never acks → o_m_wb_err[3]=o_m_wb_ack[3]=1 on the 8th granted cycle, then one cycle with o_wb_cyc=0, then IDLE.
5. TIMEOUT=8, ack on the 8th cycle → no err; single-beat transfer completes normally.
6. Assert i_reset_n=0 mid-burst on ch2 → o_wb_cyc=0 and o_grant=0 without waiting for a clock edge; after release, ch0 wins ties.
